// File: rtl/btn_debounce_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : btn_debounce_bank_pkg                                             |
// | Purpose : Shared definitions for the push-button debounce bank: per-channel |
// |           FSM state encoding, default debounce lengths and width helper.    |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package btn_debounce_bank_pkg;

  // Per-channel debounce FSM states (explicit 2-bit encoding)
  typedef enum logic [1:0] {
    LOW  = 2'd0,
    RISE = 2'd1,
    HIGH = 2'd2,
    FALL = 2'd3
  } btn_state_e;

  // Default debounce lengths: long on silicon, short for simulation runs
  localparam int DEBOUNCE_CYCLES_SYN = 16;
  localparam int DEBOUNCE_CYCLES_SIM = 4;

  // Bits needed to hold the values 0..n inclusive
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : btn_debounce_ch                                                   |
// | Purpose : One button channel: 2-flop synchroniser, LOW/RISE/HIGH/FALL       |
// |           debounce FSM with saturating counter, registered level and        |
// |           one-cycle press/release pulses. Optional auto-repeat of press     |
// |           while held, enabled by macro BTN_AUTOREPEAT_EN.                   |
// | Ports   : Clk           in  system clock (rising edge)                      |
// |           Reset         in  asynchronous active-high reset                  |
// |           btn_raw       in  raw asynchronous pin, 1 = pressed               |
// |           level         out debounced state                                 |
// |           press         out 1-cycle pulse on accepted press / auto-repeat   |
// |           release_pulse out 1-cycle pulse on accepted release               |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module btn_debounce_ch
  import btn_debounce_bank_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYN,
  parameter int HOLD_DELAY      = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (DEBOUNCE_CYCLES < 1 || HOLD_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("btn_debounce_ch: DEBOUNCE_CYCLES, HOLD_DELAY and REPEAT_PERIOD must be >= 1");
  end

  // Synchroniser: only s feeds the FSM
  logic sync_meta;
  logic s;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_meta <= 1'b0;
      s         <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      s         <= sync_meta;
    end
  end

  btn_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_nxt, release_nxt;
  logic             press_d;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    unique case (state)
      LOW: begin
        if (s) begin
          state_nxt = RISE;
          cnt_nxt   = CNT_ONE;
        end
      end
      RISE: begin
        if (!s) begin
          state_nxt = LOW;          // bounce: drop progress silently
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_ONE; // cnt < CNT_MAX here, so it saturates
        end
      end
      HIGH: begin
        if (!s) begin
          state_nxt = FALL;
          cnt_nxt   = CNT_ONE;
        end
      end
      FALL: begin
        if (s) begin
          state_nxt = HIGH;         // bounce back: no pulse
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt   = LOW;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt     = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = cnt_width(REP_MAX);
  localparam logic [REP_W-1:0] HOLD_LAST = REP_W'(HOLD_DELAY - 1);
  localparam logic [REP_W-1:0] REP_LAST  = REP_W'(REPEAT_PERIOD - 1);

  // rep_phase = 0 while waiting for the first repeat, 1 afterwards
  logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
  logic             rep_phase, rep_phase_nxt;
  logic             repeat_hit;

  always_comb begin
    rep_cnt_nxt   = '0;
    rep_phase_nxt = 1'b0;
    repeat_hit    = 1'b0;
    // Only counts while staying in HIGH; a pulse is never issued on the
    // edge that leaves HIGH, so none can appear while in FALL.
    if (state == HIGH && state_nxt == HIGH) begin
      if (rep_cnt == (rep_phase ? REP_LAST : HOLD_LAST)) begin
        repeat_hit    = 1'b1;
        rep_phase_nxt = 1'b1;
      end else begin
        rep_cnt_nxt   = rep_cnt + REP_W'(1);
        rep_phase_nxt = rep_phase;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else begin
      rep_cnt   <= rep_cnt_nxt;
      rep_phase <= rep_phase_nxt;
    end
  end

  assign press_d = press_nxt | repeat_hit;
`else
  assign press_d = press_nxt;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= LOW;
      cnt           <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      level         <= (state_nxt == HIGH) || (state_nxt == FALL);
      press         <= press_d;
      release_pulse <= release_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/btn_debounce_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : btn_debounce_bank                                                 |
// | Purpose : Front-end for N_BTN board push-buttons. Each pin is synchronised  |
// |           and debounced independently, giving a clean level plus 1-cycle    |
// |           press/release pulses. Macro BTN_AUTOREPEAT_EN adds auto-repeat    |
// |           press pulses while a button is held.                              |
// | Ports   : Clk          in  system clock (rising edge)                       |
// |           Reset        in  asynchronous active-high reset                   |
// |           btn_raw      in  [N_BTN] raw pins, 1 = pressed                    |
// |           btn_level    out [N_BTN] debounced state                          |
// |           btn_press    out [N_BTN] press / auto-repeat pulses               |
// |           btn_release  out [N_BTN] release pulses                           |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module btn_debounce_bank
  import btn_debounce_bank_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYN,
  parameter int HOLD_DELAY      = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  // Fully independent channels: no shared state, no priority
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_DELAY      (HOLD_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .Clk           (Clk),
      .Reset         (Reset),
      .btn_raw       (btn_raw[i]),
      .level         (btn_level[i]),
      .press         (btn_press[i]),
      .release_pulse (btn_release[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_btn_debounce_bank                                              |
// | Purpose : Self-checking bench for btn_debounce_bank (N_BTN=4, debounce 4,   |
// |           hold 20, repeat 8). Directed scenarios plus random stimulus,      |
// |           compared every cycle against a run-length behavioural model.      |
// |           Honours macro BTN_AUTOREPEAT_EN.                                  |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_btn_debounce_bank;

  localparam int NB = 4;
  localparam int DC = 4;
  localparam int HD = 20;
  localparam int RP = 8;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level, btn_press, btn_release;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  btn_debounce_bank #(
    .N_BTN           (NB),
    .DEBOUNCE_CYCLES (DC),
    .HOLD_DELAY      (HD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  // ---------------- behavioural model ----------------
  // A change is accepted once the synchronised input has disagreed with the
  // current level for DC+1 consecutive samples; synchronised input is the raw
  // pin as seen two clock edges earlier.
  bit            d1 [NB];
  bit            d2 [NB];
  bit            lvl[NB];
  int            run[NB];
  int            held[NB];
  logic [NB-1:0] m_level, m_press, m_rel;

  task automatic model_reset();
    for (int c = 0; c < NB; c++) begin
      d1[c] = 0; d2[c] = 0; lvl[c] = 0; run[c] = 0; held[c] = 0;
    end
    m_level = '0; m_press = '0; m_rel = '0;
  endtask

  task automatic model_step(input logic [NB-1:0] r);
    bit s, prev_high, now_high;
    for (int c = 0; c < NB; c++) begin
      s     = d2[c];
      d2[c] = d1[c];
      d1[c] = r[c];
      prev_high  = lvl[c] && run[c] == 0;
      m_press[c] = 1'b0;
      m_rel[c]   = 1'b0;
      if (s != lvl[c]) begin
        run[c]++;
        if (run[c] == DC + 1) begin
          lvl[c] = s;
          run[c] = 0;
          if (s) m_press[c] = 1'b1;
          else   m_rel[c]   = 1'b1;
        end
      end else begin
        run[c] = 0;
      end
      now_high = lvl[c] && run[c] == 0;
      if (now_high) begin
        if (!prev_high) held[c] = 0;
        else begin
          held[c]++;
          if (AUTOREP && (held[c] == HD || (held[c] > HD && (held[c] - HD) % RP == 0)))
            m_press[c] = 1'b1;
        end
      end
      m_level[c] = lvl[c];
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge Clk) begin
    check("level",   32'(btn_level),   32'(m_level));
    check("press",   32'(btn_press),   32'(m_press));
    check("release", 32'(btn_release), 32'(m_rel));
    check("press_and_release", 32'(btn_press & btn_release), 32'd0);
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a negedge; returns at the following negedge.
  task automatic step(input logic [NB-1:0] r);
    btn_raw = r;
    @(posedge Clk);
    if (!Reset) model_step(r);
    @(negedge Clk);
  endtask

  task automatic pulse_reset();
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    check("reset_outputs", 32'({btn_level, btn_press, btn_release}), 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    #2;
    Reset = 1'b0;
  endtask

  int n_press, n_rel, first_idx, second_idx;

  initial begin
    Reset   = 1'b1;
    btn_raw = '0;
    model_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("reset_state", 32'({btn_level, btn_press, btn_release}), 32'd0);
    #2;
    Reset = 1'b0;

    // 1: clean press on channel 0, accepted on the 7th edge
    for (int i = 1; i <= 8; i++) begin
      step(4'b0001);
      if (i == 6) check("t1_level_before", 32'(btn_level), 32'h0);
      if (i == 7) begin
        check("t1_press",  32'(btn_press), 32'h1);
        check("t1_level",  32'(btn_level), 32'h1);
      end
      if (i == 8) check("t1_press_one_cycle", 32'(btn_press), 32'h0);
    end

    // 2: bounce on channel 1, final rise at step 9
    n_press = 0; n_rel = 0; first_idx = -1;
    for (int i = 1; i <= 25; i++) begin
      logic b;
      b = (i <= 8) ? ((((i - 1) / 2) % 2) == 0) : 1'b1;
      step({2'b00, b, 1'b1});
      if (btn_press[1]) begin
        n_press++;
        if (first_idx < 0) first_idx = i;
      end
      if (btn_release[1]) n_rel++;
    end
    check("t2_press_count", 32'(n_press), 32'd1);
    check("t2_press_step",  32'(first_idx), 32'd15);
    check("t2_no_release",  32'(n_rel), 32'd0);

    // 3: release channel 0
    for (int i = 1; i <= 8; i++) begin
      step(4'b0010);
      if (i == 6) check("t3_level_held", 32'(btn_level), 32'h3);
      if (i == 7) begin
        check("t3_release", 32'(btn_release), 32'h1);
        check("t3_level",   32'(btn_level),   32'h2);
      end
    end

    // 4: simultaneous press on all channels
    repeat (12) step(4'b0000);
    for (int i = 1; i <= 7; i++) begin
      step(4'b1111);
      if (i == 6) check("t4_no_press_yet", 32'(btn_press), 32'h0);
      if (i == 7) check("t4_press_all",    32'(btn_press), 32'hF);
    end

    // 5: reset while channel 3 is in RISE with cnt=2
    repeat (12) step(4'b0000);
    repeat (4) step(4'b1000);
    pulse_reset();
    for (int i = 1; i <= 7; i++) begin
      step(4'b1000);
      if (i == 6) check("t5_level_before", 32'(btn_level), 32'h0);
      if (i == 7) begin
        check("t5_press", 32'(btn_press), 32'h8);
        check("t5_level", 32'(btn_level), 32'h8);
      end
    end

    // 6: hold channel 2 for 60 cycles (auto-repeat only with the macro)
    repeat (12) step(4'b0000);
    n_press = 0; first_idx = -1; second_idx = -1;
    for (int i = 1; i <= 60; i++) begin
      step(4'b0100);
      if (btn_press[2]) begin
        n_press++;
        if (first_idx < 0) first_idx = i;
        else if (second_idx < 0) second_idx = i;
      end
    end
    check("t6_first_press", 32'(first_idx), 32'd7);
    check("t6_press_count", 32'(n_press), AUTOREP ? 32'd6 : 32'd1);
    check("t6_second_press", 32'(second_idx), AUTOREP ? 32'd27 : 32'hFFFFFFFF);
    n_press = 0; n_rel = 0;
    for (int i = 1; i <= 40; i++) begin
      step(4'b0000);
      if (btn_press[2])   n_press++;
      if (btn_release[2]) n_rel++;
    end
    check("t6_no_press_after", 32'(n_press), 32'd0);
    check("t6_one_release",    32'(n_rel),   32'd1);

    // Random: fast toggling, then long holds to exercise repeats
    begin
      logic [NB-1:0] r;
      r = '0;
      for (int i = 0; i < 4000; i++) begin
        for (int c = 0; c < NB; c++) begin
          if (i < 2000) begin
            if ($urandom_range(0, 5) == 0) r[c] = ~r[c];
          end else begin
            if ($urandom_range(0, 60) == 0) r[c] = ~r[c];
          end
        end
        step(r);
        if ($urandom_range(0, 799) == 0) pulse_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
